// File: rtl/sequence_checker_lock.sv
// Purpose : receive-side checker for a periodic serial test pattern (hunt, verify, lock, loss).
// Latency : match/locked/err_cnt are registered, updated the cycle after the sampled bit.
// Backpr. : none; valid_in=0 cycles are skipped without disturbing alignment.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous reset, active low
//   valid_in - data_in carries a bit this cycle
//   data_in  - serial bit, MSB of PATTERN first
//   clr_err  - synchronous clear of err_cnt (wins over a same-cycle increment)
//   match    - 1-cycle pulse after a complete correct period
//   locked   - high while in LOCK
//   err_cnt  - bad periods seen while locked, saturating
module sequence_checker_lock #(
  parameter int             N        = 6,
  parameter logic [N-1:0]   PATTERN  = 6'b001011,
  parameter int             LOCK_CNT = 2,
  parameter int             LOSS_CNT = 2,
  parameter int             ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             data_in,
  input  logic             clr_err,
  output logic             match,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int PH_W   = (N > 1) ? $clog2(N) : 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  // Only the N-1 most recent bits need storing; the incoming bit completes the window.
  logic [N-2:0]        r_sr;
  logic [PH_W-1:0]     r_ph, w_ph_nx;
  logic [GOOD_W-1:0]   r_good, w_good_nx, w_good_inc;
  logic [BAD_W-1:0]    r_bad, w_bad_nx, w_bad_inc;
  logic                r_match, w_match_nx;
  logic                r_locked;
  logic [ERR_W-1:0]    r_err;
  logic                w_err_inc;

  logic [N-1:0]        w_win;
  logic                w_pat_ok;
  logic                w_boundary;

  assign w_win      = {r_sr, data_in};
  assign w_pat_ok   = (w_win == PATTERN);
  assign w_boundary = (r_ph == PH_W'(N - 1));
  assign w_good_inc = r_good + GOOD_W'(1);
  assign w_bad_inc  = r_bad + BAD_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    w_good_nx  = r_good;
    w_bad_nx   = r_bad;
    w_match_nx = 1'b0;
    w_err_inc  = 1'b0;

    if (valid_in) begin
      w_ph_nx = w_boundary ? '0 : r_ph + PH_W'(1);
      case (r_state)
        HUNT: begin
          // Every bit is a candidate alignment; a hit defines phase 0 at this bit.
          if (w_pat_ok) begin
            w_match_nx = 1'b1;
            w_ph_nx    = '0;
            w_good_nx  = GOOD_W'(1);
            w_bad_nx   = '0;
            w_state_nx = (LOCK_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (w_boundary) begin
            if (w_pat_ok) begin
              w_match_nx = 1'b1;
              w_good_nx  = w_good_inc;
              if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                w_state_nx = LOCK;
                w_bad_nx   = '0;
              end
            end else begin
              w_state_nx = HUNT;
              w_good_nx  = '0;
            end
          end
        end
        LOCK: begin
          if (w_boundary) begin
            if (w_pat_ok) begin
              w_match_nx = 1'b1;
              w_bad_nx   = '0;
            end else begin
              w_err_inc = 1'b1;
              w_bad_nx  = w_bad_inc;
              if (w_bad_inc == BAD_W'(LOSS_CNT)) begin
                w_state_nx = HUNT;
                w_good_nx  = '0;
              end
            end
          end
        end
        default: begin
          w_state_nx = HUNT;
          w_good_nx  = '0;
          w_bad_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_sr     <= '0;
      r_ph     <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_match  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ph     <= w_ph_nx;
      r_good   <= w_good_nx;
      r_bad    <= w_bad_nx;
      r_match  <= w_match_nx;
      // Registered copy of the next state so locked tracks state==LOCK exactly.
      r_locked <= (w_state_nx == LOCK);
      if (valid_in) begin
        r_sr <= w_win[N-2:0];
      end
    end
  end

  // Error counter: clear has priority; at all-ones it holds while bad/LOSS still advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (clr_err) begin
      r_err <= '0;
    end else if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign match   = r_match;
  assign locked  = r_locked;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_sequence_checker_lock.sv
module tb_sequence_checker_lock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       data_in;
  logic       clr_err;
  logic       match;
  logic       locked;
  logic [7:0] err_cnt;
  logic       match2;
  logic       locked2;
  logic [1:0] err2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       v;
    logic       d;
    logic       c;
    logic       em;
    logic       el;
    logic [7:0] ee;
  } vec_t;

  vec_t tbl[48];

  always #5 clk = ~clk;

  sequence_checker_lock dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .data_in  (data_in),
    .clr_err  (clr_err),
    .match    (match),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  sequence_checker_lock #(.LOSS_CNT(8), .ERR_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .data_in  (data_in),
    .clr_err  (clr_err),
    .match    (match2),
    .locked   (locked2),
    .err_cnt  (err2)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic c);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_period(input logic [5:0] p, input logic clr_last);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, p[5-i], clr_last && (i == 5));
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    logic [5:0] badp;
    logic [5:0] t4p[4];
    int         ebase[4];
    int         cnt;

    pat      = 6'b001011;
    badp     = 6'b001111;
    t4p[0]   = badp; t4p[1] = pat; t4p[2] = badp; t4p[3] = badp;
    ebase[0] = 0;    ebase[1] = 1; ebase[2] = 1;    ebase[3] = 2;

    // Clean stream: match at every 6th bit, locked from the 12th bit on.
    for (int k = 0; k < 24; k++) begin
      tbl[k] = '{1'b1, pat[5 - (k % 6)], 1'b0, (k % 6) == 5, k >= 11, 8'd0};
    end
    // After lock: bad, good, bad, bad periods.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) begin
        tbl[24 + p*6 + i] = '{1'b1, t4p[p][5-i], 1'b0,
                              (p == 1) && (i == 5),
                              !((p == 3) && (i == 5)),
                              8'(ebase[p] + (((i == 5) && (p != 1)) ? 1 : 0))};
      end
    end

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    clr_err  = 1'b0;

    // T1: outputs stay quiet under reset whatever the inputs do.
    for (int k = 0; k < 8; k++) begin
      step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      chk($sformatf("t1_match_%0d", k), match, 0);
      chk($sformatf("t1_locked_%0d", k), locked, 0);
      chk($sformatf("t1_err_%0d", k), err_cnt, 0);
      chk($sformatf("t1_err2_%0d", k), err2, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // T2
    for (int k = 0; k < 24; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].c);
      chk($sformatf("t2_match_%0d", k), match, tbl[k].em);
      chk($sformatf("t2_locked_%0d", k), locked, tbl[k].el);
      chk($sformatf("t2_err_%0d", k), err_cnt, tbl[k].ee);
    end

    // T3: gapped valid with junk data on invalid cycles.
    do_reset();
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b1, pat[5 - (k % 6)], 1'b0);
      cnt += int'(match);
      step(1'b0, 1'($urandom % 2), 1'b0);
      cnt += int'(match);
    end
    chk("t3_match_count", 8'(cnt), 4);
    chk("t3_locked", locked, 1);
    chk("t3_err", err_cnt, 0);

    // T4: continues from the locked, aligned state above.
    for (int k = 24; k < 48; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].c);
      chk($sformatf("t4_match_%0d", k), match, tbl[k].em);
      chk($sformatf("t4_locked_%0d", k), locked, tbl[k].el);
      chk($sformatf("t4_err_%0d", k), err_cnt, tbl[k].ee);
    end

    // T5: long runs of ones/zeros must not produce a false alignment.
    do_reset();
    cnt = 0;
    for (int k = 0; k < 24; k++) begin step(1'b1, 1'b1, 1'b0); cnt += int'(match); end
    for (int k = 0; k < 24; k++) begin step(1'b1, 1'b0, 1'b0); cnt += int'(match); end
    step(1'b1, 1'b1, 1'b0); cnt += int'(match);
    step(1'b1, 1'b1, 1'b0); cnt += int'(match);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pat[5-i], 1'b0);
      if (i < 5) cnt += int'(match);
    end
    chk("t5_early_match", 8'(cnt), 0);
    chk("t5_first_match", match, 1);
    chk("t5_locked_after_p1", locked, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pat[5-i], 1'b0);
      if (i < 5) cnt += int'(match);
    end
    chk("t5_mid_match", 8'(cnt), 0);
    chk("t5_second_match", match, 1);
    chk("t5_locked_after_p2", locked, 1);

    // T6: narrow saturating counter, long loss window (dut2).
    do_reset();
    send_period(pat, 1'b0);
    send_period(pat, 1'b0);
    chk("t6_locked_init", locked2, 1);
    for (int p = 0; p < 5; p++) send_period(badp, 1'b0);
    chk("t6_err_sat", err2, 3);
    chk("t6_locked_after5", locked2, 1);
    send_period(badp, 1'b1);
    chk("t6_err_clr", err2, 0);
    chk("t6_locked_after6", locked2, 1);
    send_period(badp, 1'b0);
    chk("t6_err_after7", err2, 1);
    chk("t6_locked_after7", locked2, 1);
    send_period(badp, 1'b0);
    chk("t6_err_after8", err2, 2);
    chk("t6_locked_after8", locked2, 0);
    send_period(pat, 1'b0);
    send_period(pat, 1'b0);
    chk("t6_relocked", locked2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_async_locked2", locked2, 0);
    chk("t6_async_err2", err2, 0);
    chk("t6_async_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, pat[5 - (i % 6)], 1'b0);
      if (i == 10) chk("t6_relock_bit11", locked2, 0);
      if (i == 11) begin
        chk("t6_relock_bit12", locked2, 1);
        chk("t6_relock_match", match2, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
